servo_sweep_multi: RTL

Multi-channel successor to the single-servo sweep controller. One shared frame counter drives NCH independent servo channels. Each channel ramps its position up or down by STEP once per frame, driven by per-channel toggle/freeze inputs, and emits a real PWM pulse of width PULSE_MIN+position. A selectable 16-bit status word keeps the existing data_out display format for the 7-segment/LCD path.

---
 rtl/servo_sweep_multi_if.sv | 29 ++
 rtl/servo_sweep_multi.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep_multi_if.sv
// servo_sweep_multi_if: control inputs and status/PWM outputs of the multi-channel servo sweeper.
// Latency: none, wires only; timing is set by the module driving the slave side.
// Backpressure: none; every signal is a level, sampled or driven each mclk cycle.
interface servo_sweep_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 15,
  parameter int POS_W = 12,
  parameter int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]       toggle;
  logic [NCH-1:0]       freeze;
  logic [SEL_W-1:0]     sel;
  logic [NCH-1:0]       pwm;
  logic                 frame_tick;
  logic [CNT_W-1:0]     counter;
  logic [NCH*POS_W-1:0] pos_flat;
  logic [15:0]          data_out;
  logic [NCH-1:0]       Led;

  modport master (
    output toggle, freeze, sel,
    input  pwm, frame_tick, counter, pos_flat, data_out, Led
  );

  modport slave (
    input  toggle, freeze, sel,
    output pwm, frame_tick, counter, pos_flat, data_out, Led
  );
endinterface

// File: rtl/servo_sweep_multi.sv
// servo_sweep_multi: one shared frame counter, NCH servo channels ramping by STEP per frame, PWM = PULSE_MIN+pos.
// Latency: new position and pwm take effect at the wrap edge; data_out follows sel after 1 cycle.
// Backpressure: none, free-running. Define SERVO_INPUT_SYNC_EN to add 2-flop toggle/freeze synchronisers.
module servo_sweep_multi #(
  parameter int NCH         = 4,
  parameter int FRAME_TICKS = 20000,
  parameter int CNT_W       = 15,
  parameter int PULSE_MIN   = 1000,
  parameter int POS_MAX     = 1000,
  parameter int STEP        = 10,
  parameter int POS_W       = 12
) (
  input  logic               mclk,
  input  logic               rst,
  servo_sweep_multi_if.slave bus
);

  // One extra bit so PULSE_MIN+pos can never wrap inside the compare.
  localparam int CMP_W = ((CNT_W > POS_W) ? CNT_W : POS_W) + 1;
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_TICKS - 1);
  localparam logic [POS_W-1:0] POS_MAX_V   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] STEP_V      = POS_W'(STEP);
  localparam logic [CMP_W-1:0] PULSE_MIN_V = CMP_W'(PULSE_MIN);

  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_next;
  logic             w_wrap;

  logic [NCH-1:0]   w_toggle;
  logic [NCH-1:0]   w_freeze;

  logic [POS_W-1:0] r_pos      [NCH];
  logic [POS_W-1:0] w_pos_next [NCH];
  logic [POS_W-1:0] w_pos_up   [NCH];
  logic [7:0]       r_idx      [NCH];
  logic [7:0]       w_idx_next [NCH];
  logic [NCH-1:0]   r_dir;
  logic [NCH-1:0]   r_frz;
  logic [NCH-1:0]   w_dir_next;
  logic [NCH-1:0]   w_frz_next;

  logic [NCH-1:0]   r_pwm;
  logic [NCH-1:0]   w_pwm_next;

  logic [15:0]      r_data_out;
  logic [15:0]      w_status;

`ifdef SERVO_INPUT_SYNC_EN
  logic [NCH-1:0] r_tog_s1;
  logic [NCH-1:0] r_tog_s2;
  logic [NCH-1:0] r_frz_s1;
  logic [NCH-1:0] r_frz_s2;

  // Two-flop synchronisers for the asynchronous toggle/freeze pins.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_tog_s1 <= '0;
      r_tog_s2 <= '0;
      r_frz_s1 <= '0;
      r_frz_s2 <= '0;
    end else begin
      r_tog_s1 <= bus.toggle;
      r_tog_s2 <= r_tog_s1;
      r_frz_s1 <= bus.freeze;
      r_frz_s2 <= r_frz_s1;
    end
  end

  assign w_toggle = r_tog_s2;
  assign w_freeze = r_frz_s2;
`else
  assign w_toggle = bus.toggle;
  assign w_freeze = bus.freeze;
`endif

  assign w_wrap         = (r_counter == LAST_CNT);
  assign w_counter_next = w_wrap ? '0 : r_counter + CNT_W'(1);

  // Shared frame counter, wraps to 0 after FRAME_TICKS-1.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_counter <= '0;
    end else begin
      r_counter <= w_counter_next;
    end
  end

  // Per-channel next state: inputs only matter on the wrap edge; ramps clamp at 0 and POS_MAX.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_pos_next[i] = r_pos[i];
      w_idx_next[i] = r_idx[i];
      w_dir_next[i] = r_dir[i];
      w_frz_next[i] = r_frz[i];
      w_pos_up[i]   = r_pos[i] + STEP_V;
      if (w_wrap) begin
        w_dir_next[i] = w_toggle[i];
        w_frz_next[i] = w_freeze[i];
        if (!w_freeze[i]) begin
          if (w_toggle[i]) begin
            if (r_pos[i] < POS_MAX_V) begin
              w_pos_next[i] = (w_pos_up[i] > POS_MAX_V) ? POS_MAX_V : w_pos_up[i];
              w_idx_next[i] = r_idx[i] + 8'd1;
            end
          end else if (r_pos[i] != '0) begin
            w_pos_next[i] = (r_pos[i] > STEP_V) ? (r_pos[i] - STEP_V) : '0;
            w_idx_next[i] = r_idx[i] - 8'd1;
          end
        end
      end
    end
  end

  // PWM decision uses next-state counter/position so the registered pulse lines up with the counter.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_pwm_next[i] = (CMP_W'(w_counter_next) < (PULSE_MIN_V + CMP_W'(w_pos_next[i])));
    end
  end

  // Channel position, step index and flags.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_pos[i] <= '0;
        r_idx[i] <= '0;
      end
      r_dir <= '0;
      r_frz <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_pos[i] <= w_pos_next[i];
        r_idx[i] <= w_idx_next[i];
      end
      r_dir <= w_dir_next;
      r_frz <= w_frz_next;
    end
  end

  // Registered PWM outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end

  // Status word of the selected channel; out-of-range selects show the idle pattern.
  always_comb begin
    w_status = 16'h4000;
    for (int i = 0; i < NCH; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        w_status = {2'b01, 2'b00, r_idx[i][7:4], 2'b00, r_idx[i][3:0], r_dir[i], r_frz[i]};
      end
    end
  end

  // Status word register, refreshed every cycle.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_data_out <= 16'h4000;
    end else begin
      r_data_out <= w_status;
    end
  end

  assign bus.pwm        = r_pwm;
  assign bus.frame_tick = (r_counter == '0);
  assign bus.counter    = r_counter;
  assign bus.data_out   = r_data_out;
  assign bus.Led        = bus.toggle;

  for (genvar g = 0; g < NCH; g++) begin : g_pos_flat
    assign bus.pos_flat[g*POS_W +: POS_W] = r_pos[g];
  end

endmodule
